// File: rtl/expansion_pipe.sv
// ---------------------------------------------------------------------------
// expansion_pipe
//
// Multi-lane expansion stage. Each lane widens a 32-bit right-half word into
// 48 bits. Every 6-bit group g is {r[4g+4], r[4g+3:4g], r[4g-1]}, with the bit
// indices wrapping modulo 32. The 48-bit result is optionally XORed with a
// per-lane subkey. Results travel through a valid/ready pipeline of STAGES
// slots. Empty slots collapse, so a bubble never stalls upstream.
//
// Parameters
//   LANES   number of independent 32-bit channels (1..4)
//   STAGES  register slots between input and output (1..4)
//
// Ports
//   clk         sole clock, rising edge
//   n_rst       synchronous reset, active HIGH (1 = reset)
//   in_valid    input beat present
//   in_ready    block accepts a beat this cycle (never depends on in_valid)
//   re_32bit    LANES x 32 input words, lane k at [32k+31:32k]
//   subkey      LANES x 48 subkeys, lane k at [48k+47:48k]
//   key_mix_en  1 = XOR subkey into the expansion, captured with the beat
//   out_valid   output beat present
//   out_ready   downstream accepts output
//   re_48bit    LANES x 48 results, lane k at [48k+47:48k]; 0 when idle
//   out_parity  per-lane even parity of re_48bit; 0 when idle
//
// Build option
//   EXPANSION_PARITY_EN  when defined, parity is computed at the input and
//                        carried with its beat. Otherwise out_parity is tied
//                        to 0 and no parity registers exist.
// ---------------------------------------------------------------------------
module expansion_pipe #(
  parameter int LANES  = 1,
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   re_32bit,
  input  logic [LANES*48-1:0]   subkey,
  input  logic                  key_mix_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*48-1:0]   re_48bit,
  output logic [LANES-1:0]      out_parity
);

  localparam int W    = LANES * 48;
  localparam int LAST = STAGES - 1;

  // Expansion permutation for one lane. Group 0 borrows r[31] and group 7
  // borrows r[0], so the word wraps around at both ends.
  function automatic logic [47:0] expand(input logic [31:0] r);
    logic [47:0] e;
    e = '0;
    for (int g = 0; g < 8; g++) begin
      e[6*g +: 6] = {r[(4*g + 4) % 32], r[4*g +: 4], r[(4*g + 31) % 32]};
    end
    return e;
  endfunction

  // Result of the beat on the input, computed before it enters slot 0.
  logic [W-1:0] in_result;

  // NOTE: every always_comb output is assigned a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    in_result = '0;
    for (int k = 0; k < LANES; k++) begin
      in_result[48*k +: 48] = expand(re_32bit[32*k +: 32])
                              ^ ({48{key_mix_en}} & subkey[48*k +: 48]);
    end
  end

  // Pipeline slot state.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] load;
  logic [W-1:0]      data_q [STAGES];

  // A slot loads when it is empty or its occupant moves on this cycle.
  // The chain is evaluated from the output back toward the input, so a
  // hole anywhere downstream lets every upstream slot advance.
  always_comb begin
    load       = '0;
    load[LAST] = !valid_q[LAST] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      load[i] = !valid_q[i] || load[i + 1];
    end
  end

  // Reset forces both handshakes low, including the first reset cycle
  // before the valid bits have been cleared.
  assign in_ready  = !n_rst && load[0];
  assign out_valid = !n_rst && valid_q[LAST];

  // NOTE: sequential state uses non-blocking assignments only, so each slot
  // reads its upstream neighbour's value from before the edge.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      valid_q <= '0;
    end else begin
      if (load[0]) valid_q[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) valid_q[i] <= valid_q[i - 1];
      end
    end
  end

  // NOTE: payload registers are not reset. Only the valid bits carry
  // meaning, and the output mux below hides stale data.
  always_ff @(posedge clk) begin
    if (load[0]) data_q[0] <= in_result;
    for (int i = 1; i < STAGES; i++) begin
      if (load[i]) data_q[i] <= data_q[i - 1];
    end
  end

  assign re_48bit = out_valid ? data_q[LAST] : '0;

`ifdef EXPANSION_PARITY_EN
  logic [LANES-1:0] in_parity;
  logic [LANES-1:0] par_q [STAGES];

  always_comb begin
    in_parity = '0;
    for (int k = 0; k < LANES; k++) begin
      in_parity[k] = ^in_result[48*k +: 48];
    end
  end

  // Parity moves in lockstep with its beat, using the same load enables.
  always_ff @(posedge clk) begin
    if (load[0]) par_q[0] <= in_parity;
    for (int i = 1; i < STAGES; i++) begin
      if (load[i]) par_q[i] <= par_q[i - 1];
    end
  end

  assign out_parity = out_valid ? par_q[LAST] : '0;
`else
  assign out_parity = '0;
`endif

endmodule

// File: tb/tb_expansion_pipe.sv
// ---------------------------------------------------------------------------
// tb_expansion_pipe
//
// Bench for expansion_pipe. The main instance uses LANES=1 and STAGES=2. A
// second instance with LANES=4 and STAGES=3 exercises independent lanes.
// Expected results come from a bit-by-bit model of the expansion and go into
// a scoreboard queue when a beat is accepted. The monitor pops and compares
// them when the DUT delivers a beat. Inputs are driven 1 time unit after the
// rising edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_expansion_pipe;

  localparam int STAGES = 2;
  localparam int L4     = 4;
  localparam int S4     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (LANES=1)
  logic        n_rst;
  logic        in_valid, in_ready, out_valid, out_ready, key_mix_en;
  logic [31:0] re_32bit;
  logic [47:0] subkey, re_48bit;
  logic [0:0]  out_parity;

  // Four-lane DUT
  logic            in_valid4, in_ready4, out_valid4, out_ready4, key_mix_en4;
  logic [L4*32-1:0] re_32bit4;
  logic [L4*48-1:0] subkey4, re_48bit4;
  logic [L4-1:0]    out_parity4;

  expansion_pipe #(.LANES(1), .STAGES(STAGES)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .re_32bit(re_32bit), .subkey(subkey), .key_mix_en(key_mix_en),
    .out_valid(out_valid), .out_ready(out_ready), .re_48bit(re_48bit),
    .out_parity(out_parity)
  );

  expansion_pipe #(.LANES(L4), .STAGES(S4)) dut4 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .re_32bit(re_32bit4), .subkey(subkey4), .key_mix_en(key_mix_en4),
    .out_valid(out_valid4), .out_ready(out_ready4), .re_48bit(re_48bit4),
    .out_parity(out_parity4)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [47:0] data;
    logic        par;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Model written per output bit: bit j sits at position p = j%6 of group
  // g = j/6. Position 5 takes r[4g+4], position 0 takes r[4g-1], and the
  // middle positions take r[4g+p-1] (indices modulo 32).
  function automatic logic [47:0] model(input logic [31:0] r, input logic [47:0] sk,
                                        input logic km);
    logic [47:0] e;
    int g, p;
    for (int j = 0; j < 48; j++) begin
      g = j / 6;
      p = j % 6;
      if (p == 5)      e[j] = r[(4*g + 4) % 32];
      else if (p == 0) e[j] = r[(4*g + 31) % 32];
      else             e[j] = r[4*g + p - 1];
    end
    return km ? (e ^ sk) : e;
  endfunction

  function automatic logic model_par(input logic [47:0] v);
`ifdef EXPANSION_PARITY_EN
    return ^v;
`else
    return 1'b0 & v[0];
`endif
  endfunction

  // Monitor and scoreboard for the main DUT.
  logic        prev_stall = 1'b0;
  logic [47:0] prev_data;
  logic        prev_par;

  always @(negedge clk) begin
    if (n_rst) begin
      sb.delete();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || re_48bit !== 48'h0) begin
        errors++;
        $display("FAIL reset_outputs: out_valid=%b in_ready=%b re_48bit=%h, required 0 0 0",
                 out_valid, in_ready, re_48bit);
      end
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || re_48bit !== prev_data || out_parity[0] !== prev_par) begin
          errors++;
          $display("FAIL hold_stable: out_valid=%b data=%h par=%b, required 1 %h %b",
                   out_valid, re_48bit, out_parity[0], prev_data, prev_par);
        end
      end
      if (!out_valid) begin
        checks++;
        if (re_48bit !== 48'h0 || out_parity !== 1'b0) begin
          errors++;
          $display("FAIL idle_zero: data=%h par=%b, required 0 0", re_48bit, out_parity);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h with empty scoreboard", re_48bit);
        end else begin
          mon_e = sb.pop_front();
          if (re_48bit !== mon_e.data || out_parity[0] !== mon_e.par) begin
            errors++;
            $display("FAIL scoreboard: got %h/%b, required %h/%b",
                     re_48bit, out_parity[0], mon_e.data, mon_e.par);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{data: model(re_32bit, subkey, key_mix_en),
                       par:  model_par(model(re_32bit, subkey, key_mix_en))});
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = re_48bit;
      prev_par   = out_parity[0];
    end
  end

  task automatic rand_inputs();
    logic [63:0] t;
    t          = {$urandom(), $urandom()};
    re_32bit   = $urandom();
    subkey     = t[47:0];
    key_mix_en = 1'($urandom_range(0, 1));
  endtask

  // Drive one beat and hold it until accepted. in_valid drops afterwards.
  task automatic send(input logic [31:0] r, input logic [47:0] sk, input logic km);
    int n;
    n = 0;
    @(posedge clk); #1;
    re_32bit = r; subkey = sk; key_mix_en = km; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until the main DUT presents a beat. Ends on a falling edge.
  task automatic wait_out(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
  endtask

  // Drain with out_ready=1 until the scoreboard is empty (bounded).
  task automatic drain(input string name);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
    end
  endtask

  // Stall the output and feed beats until in_ready drops (bounded).
  // Ends on a falling edge with in_valid still high on a pending beat.
  task automatic fill_pipe(output int accepted);
    int n;
    accepted = 0;
    n = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rand_inputs();
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready && n < 10) begin
      accepted++;
      n++;
      @(posedge clk); #1;
      rand_inputs();
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    re_32bit = '0; subkey = '0; key_mix_en = 1'b0;
    re_32bit4 = '0; subkey4 = '0; key_mix_en4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || in_ready4 !== 1'b0 || out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b in_ready4=%b out_valid4=%b, required 0",
               in_ready, out_valid, in_ready4, out_valid4);
    end
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  // A beat accepted in cycle t is visible in cycle t+2.
  task automatic test_latency();
    @(posedge clk); #1;
    out_ready = 1'b1;
    re_32bit = 32'h0000_0001; subkey = 48'hA5A5_A5A5_A5A5; key_mix_en = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL latency_accept: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b at t+1, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || re_48bit !== 48'h8000_0000_0002 || out_parity !== 1'b0) begin
      errors++;
      $display("FAIL latency_value: out_valid=%b data=%h par=%b, required 1 800000000002 0",
               out_valid, re_48bit, out_parity);
    end
  endtask

  task automatic test_vectors();
    bit   ok;
    logic exp_par;
`ifdef EXPANSION_PARITY_EN
    exp_par = 1'b1;
`else
    exp_par = 1'b0;
`endif
    out_ready = 1'b1;
    send(32'h8000_0000, 48'h1234_5678_9ABC, 1'b0);
    wait_out(ok);
    checks++;
    if (!ok || re_48bit !== 48'h4000_0000_0001) begin
      errors++;
      $display("FAIL vec_msb: valid=%b data=%h, required 1 400000000001", ok, re_48bit);
    end
    send(32'hFFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b1);
    wait_out(ok);
    checks++;
    if (!ok || re_48bit !== 48'h0 || out_parity !== 1'b0) begin
      errors++;
      $display("FAIL vec_ones_mix: valid=%b data=%h par=%b, required 1 0 0",
               ok, re_48bit, out_parity);
    end
    send(32'h0000_0001, 48'h0000_0000_0001, 1'b1);
    wait_out(ok);
    checks++;
    if (!ok || re_48bit !== 48'h8000_0000_0003 || out_parity[0] !== exp_par) begin
      errors++;
      $display("FAIL vec_parity: valid=%b data=%h par=%b, required 1 800000000003 %b",
               ok, re_48bit, out_parity, exp_par);
    end
    drain("vectors");
  endtask

  // Three beats against a stalled output. Two are accepted, then all three
  // leave in order once the output is released.
  task automatic test_backpressure();
    logic [31:0] rs [3];
    int          idx;
    bit          ok;
    rs[0] = 32'hDEAD_BEEF; rs[1] = 32'h0F0F_1234; rs[2] = 32'h7654_3210;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (idx < 3) begin
        re_32bit = rs[idx]; subkey = 48'h0; key_mix_en = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
    end
    checks++;
    if (idx !== 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: accepted=%0d in_ready=%b out_valid=%b, required 2 0 1",
               idx, in_ready, out_valid);
    end
    checks++;
    if (re_48bit !== model(rs[0], 48'h0, 1'b0)) begin
      errors++;
      $display("FAIL bp_head: data=%h, required %h", re_48bit, model(rs[0], 48'h0, 1'b0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    re_32bit = rs[2]; in_valid = 1'b1;
    wait_out(ok);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("backpressure");
  endtask

  // A full pipe that drains and refills every cycle keeps occupancy at two.
  task automatic test_back_to_back();
    int acc;
    fill_pipe(acc);
    checks++;
    if (acc != STAGES || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_fill: accepted=%0d in_ready=%b, required %0d 0", acc, in_ready, STAGES);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_cycle%0d: in_ready=%b out_valid=%b, required 1 1",
                 c, in_ready, out_valid);
      end
      @(posedge clk); #1;
      rand_inputs();
    end
    drain("back_to_back");
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (!(in_valid && !in_ready)) begin
        rand_inputs();
        in_valid = 1'(($urandom_range(0, 3)) != 0);
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
    end
    drain("random");
  endtask

  // Reset with two beats in flight. Those beats must never appear.
  task automatic test_midflight_reset();
    int acc;
    fill_pipe(acc);
    @(posedge clk); #1;
    n_rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_during: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_ghost: out_valid=%b data=%h, required 0", out_valid, re_48bit);
      end
    end
  endtask

  task automatic test_lanes4();
    logic [63:0] t;
    int          n;
    for (int km = 0; km < 2; km++) begin
      @(posedge clk); #1;
      re_32bit4 = {32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
      for (int k = 0; k < L4; k++) begin
        t = {$urandom(), $urandom()};
        subkey4[48*k +: 48] = t[47:0];
      end
      key_mix_en4 = 1'(km);
      in_valid4 = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready4 && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid4 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (out_valid4 !== 1'b1 || n != S4 - 1) begin
        errors++;
        $display("FAIL lanes4_latency: out_valid4=%b waited=%0d, required 1 %0d",
                 out_valid4, n, S4 - 1);
      end
      for (int k = 0; k < L4; k++) begin
        checks++;
        if (re_48bit4[48*k +: 48] !== model(re_32bit4[32*k +: 32], subkey4[48*k +: 48], 1'(km)) ||
            out_parity4[k] !== model_par(model(re_32bit4[32*k +: 32], subkey4[48*k +: 48], 1'(km)))) begin
          errors++;
          $display("FAIL lanes4_km%0d_lane%0d: got %h/%b, required %h", km, k,
                   re_48bit4[48*k +: 48], out_parity4[k],
                   model(re_32bit4[32*k +: 32], subkey4[48*k +: 48], 1'(km)));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_midflight_reset();
    test_lanes4();
    drain("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
